// File: rtl/multiplier_8.sv
// Sequential 8x8->16 shift-and-add multiplier; define MULT8_SIGNED_EN for two's-complement operands.
// Latency: start accepted at E0, p valid and ready high after E8; one operation per 9 cycles.
// Backpressure: start is ignored while ready is low (no queuing, no restart).
module multiplier_8 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic [15:0] p,
    output logic        ready
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, state_nxt;
    logic [15:0] mcand, mcand_nxt;
    logic [15:0] acc, acc_nxt;
    logic [15:0] p_nxt;
    logic [15:0] sum;
    logic [7:0]  mplier, mplier_nxt;
    logic [7:0]  a_mag, b_mag;
    logic [2:0]  cnt, cnt_nxt;
    logic        neg, neg_nxt;

`ifdef MULT8_SIGNED_EN
    // Work on magnitudes; -128 maps to 0x80, which is correct read as unsigned.
    assign a_mag = a[7] ? (~a + 8'd1) : a;
    assign b_mag = b[7] ? (~b + 8'd1) : b;
`else
    assign a_mag = a;
    assign b_mag = b;
`endif

    // Includes the current edge's partial product so the completion edge sees the full result.
    assign sum   = acc + (mplier[0] ? mcand : 16'd0);
    assign ready = (state == IDLE);

    always_comb begin
        state_nxt  = state;
        mcand_nxt  = mcand;
        mplier_nxt = mplier;
        acc_nxt    = acc;
        cnt_nxt    = cnt;
        neg_nxt    = neg;
        p_nxt      = p;
        if (state == IDLE) begin
            if (start) begin
                state_nxt  = BUSY;
                mcand_nxt  = {8'h00, a_mag};
                mplier_nxt = b_mag;
                acc_nxt    = 16'h0000;
                cnt_nxt    = 3'd0;
`ifdef MULT8_SIGNED_EN
                neg_nxt    = a[7] ^ b[7];
`else
                neg_nxt    = 1'b0;
`endif
            end
        end else begin
            acc_nxt    = sum;
            mcand_nxt  = {mcand[14:0], 1'b0};
            mplier_nxt = {1'b0, mplier[7:1]};
            cnt_nxt    = cnt + 3'd1;
            if (cnt == 3'd7) begin
                state_nxt = IDLE;
`ifdef MULT8_SIGNED_EN
                p_nxt     = neg ? (~sum + 16'd1) : sum;
`else
                p_nxt     = sum;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= 16'h0000;
            mplier <= 8'h00;
            acc    <= 16'h0000;
            cnt    <= 3'd0;
            neg    <= 1'b0;
            p      <= 16'h0000;
        end else begin
            state  <= state_nxt;
            mcand  <= mcand_nxt;
            mplier <= mplier_nxt;
            acc    <= acc_nxt;
            cnt    <= cnt_nxt;
            neg    <= neg_nxt;
            p      <= p_nxt;
        end
    end

endmodule

// File: tb/tb_multiplier_8.sv
// Randomized and directed bench for multiplier_8 against an arithmetic product model.
module tb_multiplier_8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
    logic        ready;

    int errs   = 0;
    int checks = 0;

    multiplier_8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .p     (p),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y);
        int r;
`ifdef MULT8_SIGNED_EN
        r = int'($signed(x)) * int'($signed(y));
`else
        r = int'(x) * int'(y);
`endif
        return r[15:0];
    endfunction

    // One operation: 1-cycle start, operands scrambled afterwards, then wait for completion.
    task automatic run_op(input logic [7:0] x, input logic [7:0] y, input string tag);
        int          busy;
        logic [15:0] p0;
        bit          held;
        @(negedge clk);
        a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        p0   = p;
        busy = 0;
        held = 1'b1;
        while (!ready && busy < 20) begin
            busy++;
            if (p !== p0) held = 1'b0;
            @(negedge clk);
        end
        check({tag, " latency"}, busy, 8);
        check({tag, " p held while busy"}, 32'(held), 1);
        check({tag, " product"}, p, model(x, y));
    endtask

    initial begin
        int          busy;
        logic [7:0]  rx, ry;

        rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
        #12;
        check("reset p", p, 16'h0000);
        check("reset ready", 32'(ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of an operation discards it.
        @(negedge clk);
        a = 8'h0F; b = 8'h0F; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("midop busy", 32'(ready), 0);
        rst_n = 1'b0;
        #1;
        check("midop reset p", p, 16'h0000);
        check("midop reset ready", 32'(ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("midop no result", p, 16'h0000);
        check("midop stays idle", 32'(ready), 1);

        run_op(8'd3, 8'd5, "basic");
        repeat (5) @(negedge clk);
        check("basic stable", p, 16'h000F);

`ifdef MULT8_SIGNED_EN
        run_op(8'hFF, 8'hFF, "s -1*-1");
        check("s -1*-1 const", p, 16'h0001);
        run_op(8'h80, 8'h80, "s -128*-128");
        check("s -128*-128 const", p, 16'h4000);
        run_op(8'h80, 8'h7F, "s -128*127");
        check("s -128*127 const", p, 16'hC080);
        run_op(8'd5, 8'hFD, "s 5*-3");
        check("s 5*-3 const", p, 16'hFFF1);
`else
        run_op(8'd0, 8'd0, "0*0");
        check("0*0 const", p, 16'h0000);
        run_op(8'd255, 8'd255, "255*255");
        check("255*255 const", p, 16'hFE01);
        run_op(8'd255, 8'd1, "255*1");
        check("255*1 const", p, 16'h00FF);
        run_op(8'd1, 8'd255, "1*255");
        check("1*255 const", p, 16'h00FF);
`endif

        // Second start while busy must be ignored.
        @(negedge clk);
        a = 8'd10; b = 8'd20; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy = 0;
        while (!ready && busy < 20) begin
            busy++;
            if (busy == 4) begin
                a = 8'd1; b = 8'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("busyign latency", busy, 8);
        check("busyign product", p, 16'h00C8);
        repeat (12) @(negedge clk);
        check("busyign no 2nd op ready", 32'(ready), 1);
        check("busyign no 2nd op p", p, 16'h00C8);

        // start held high: back-to-back ops with a single idle cycle between.
        @(negedge clk);
        a = 8'd7; b = 8'd9; start = 1'b1;
        @(negedge clk);
        busy = 0;
        while (!ready && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        check("held1 latency", busy, 8);
        check("held1 product", p, model(8'd7, 8'd9));
        a = 8'd2; b = 8'd3;
        @(negedge clk);
        check("held relaunch", 32'(ready), 0);
        busy = 1;
        @(negedge clk);
        while (!ready && busy < 20) begin
            busy++;
            @(negedge clk);
        end
        start = 1'b0;
        check("held2 latency", busy, 8);
        check("held2 product", p, model(8'd2, 8'd3));

        for (int i = 0; i < 1500; i++) begin
            rx = 8'($urandom);
            ry = 8'($urandom);
            run_op(rx, ry, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
